// File: rtl/alu_unit.sv
// Queued integer execution unit: in-order FIFO feeding single-cycle ALU ops or an
// iterative shift-add RV32M multiplier, one tagged result per cycle toward writeback.
module alu_unit #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ROB_IDW = 4,
    parameter int unsigned DEPTH   = 4,
    parameter bit          MUL_EN  = 1'b1
) (
    input  logic               clk,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               flush_in,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_type,
    input  logic [XLEN-1:0]    in_val1,
    input  logic [XLEN-1:0]    in_val2,
    input  logic [ROB_IDW:0]   in_entry,
    input  logic [XLEN-1:0]    in_pc,
    output logic               out_valid,
    output logic [ROB_IDW:0]   out_entry,
    output logic [XLEN-1:0]    out_val,
    output logic               out_redirect,
    output logic [XLEN-1:0]    out_pc
);
    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned CW  = $clog2(XLEN) + 1;
    localparam int unsigned SHW = $clog2(XLEN);
    localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

    // util.v OP_* class codes
    localparam logic [2:0] OP_I = 3'd0;
    localparam logic [2:0] OP_R = 3'd1;
    localparam logic [2:0] OP_L = 3'd2;
    localparam logic [2:0] OP_S = 3'd3;
    localparam logic [2:0] OP_B = 3'd4;

    typedef struct packed {
        logic [7:0]       typ;
        logic [XLEN-1:0]  v1;
        logic [XLEN-1:0]  v2;
        logic [ROB_IDW:0] tag;
        logic [XLEN-1:0]  pc;
    } entry_t;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    entry_t              q_mem [DEPTH];
    logic [PW-1:0]       head, tail;
    logic [PW:0]         count;
    state_t              state, state_nxt;

    logic [2*XLEN-1:0]   ma, acc, prod;
    logic [XLEN-1:0]     mb;
    logic [CW-1:0]       cnt;
    logic                m_neg, m_hi;
    logic [ROB_IDW:0]    m_tag;

    entry_t              hd;
    logic                enq, issue, hd_mul, alu_redir, s1, s2, lt, ltu;
    logic [2:0]          cls, f3;
    logic                alt;
    logic [XLEN-1:0]     a, b, sum, alu_res, jalr_tgt, abs1, abs2;
    logic [SHW-1:0]      shamt;

    assign in_ready = (count < CNT_FULL);

    always_comb begin
        hd        = q_mem[head];
        enq       = in_valid && in_ready;
        issue     = (state == S_IDLE) && (count != '0);
        cls       = hd.typ[2:0];
        f3        = hd.typ[5:3];
        alt       = hd.typ[6];
        a         = hd.v1;
        b         = hd.v2;
        sum       = a + b;
        shamt     = b[SHW-1:0];
        lt        = $signed(a) < $signed(b);
        ltu       = a < b;
        jalr_tgt  = {sum[XLEN-1:1], 1'b0};
        hd_mul    = MUL_EN && hd.typ[7] && (cls == OP_R) && !f3[2];
        s1        = (f3 != 3'b011);
        s2        = (f3[2:1] == 2'b00);
        abs1      = (s1 && a[XLEN-1]) ? -a : a;
        abs2      = (s2 && b[XLEN-1]) ? -b : b;
        prod      = m_neg ? -acc : acc;
        alu_res   = '0;
        alu_redir = 1'b0;

        // M-ext ops that reach here (MUL_EN=0 or funct3 1xx) produce 0
        if (!(hd.typ[7] && cls == OP_R)) begin
            case (cls)
                OP_I, OP_R: begin
                    case (f3)
                        3'b000:  alu_res = (alt && cls == OP_R) ? a - b : sum;
                        3'b001:  alu_res = a << shamt;
                        3'b010:  alu_res = {{(XLEN-1){1'b0}}, lt};
                        3'b011:  alu_res = alt ? sum : {{(XLEN-1){1'b0}}, ltu};
                        3'b100:  alu_res = a ^ b;
                        3'b101:  alu_res = alt ? $unsigned($signed(a) >>> shamt) : a >> shamt;
                        3'b110:  alu_res = a | b;
                        default: alu_res = a & b;
                    endcase
                end
                OP_L, OP_S: alu_res = sum;
                OP_B: begin
                    case (f3)
                        3'b000:  alu_res = {{(XLEN-1){1'b0}}, a == b};
                        3'b001:  alu_res = {{(XLEN-1){1'b0}}, a != b};
                        3'b011: begin
                            alu_res   = hd.pc;
                            alu_redir = 1'b1;
                        end
                        3'b100:  alu_res = {{(XLEN-1){1'b0}}, lt};
                        3'b101:  alu_res = {{(XLEN-1){1'b0}}, !lt};
                        3'b110:  alu_res = {{(XLEN-1){1'b0}}, ltu};
                        3'b111:  alu_res = alt ? sum : {{(XLEN-1){1'b0}}, !ltu};
                        default: alu_res = '0;
                    endcase
                end
                default: alu_res = '0;
            endcase
        end

        state_nxt = state;
        case (state)
            S_IDLE:  if (issue && hd_mul) state_nxt = S_MUL;
            S_MUL:   if (cnt == CW'(XLEN-1)) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_in)
            state <= S_IDLE;
        else if (rdy_in)
            state <= flush_in ? S_IDLE : state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_in && rdy_in && !flush_in && enq)
            q_mem[tail] <= '{typ: in_type, v1: in_val1, v2: in_val2, tag: in_entry, pc: in_pc};
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            out_valid    <= 1'b0;
            out_redirect <= 1'b0;
            out_entry    <= '0;
            out_val      <= '0;
            out_pc       <= '0;
            ma           <= '0;
            mb           <= '0;
            acc          <= '0;
            cnt          <= '0;
            m_neg        <= 1'b0;
            m_hi         <= 1'b0;
            m_tag        <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                head         <= '0;
                tail         <= '0;
                count        <= '0;
                out_valid    <= 1'b0;
                out_redirect <= 1'b0;
            end else begin
                if (enq)
                    tail <= tail + PW'(1);
                if (issue)
                    head <= head + PW'(1);
                count        <= count + {{PW{1'b0}}, enq} - {{PW{1'b0}}, issue};
                out_valid    <= 1'b0;
                out_redirect <= 1'b0;
                case (state)
                    S_IDLE: begin
                        if (issue && hd_mul) begin
                            ma    <= {{XLEN{1'b0}}, abs1};
                            mb    <= abs2;
                            acc   <= '0;
                            cnt   <= '0;
                            m_neg <= (s1 && a[XLEN-1]) ^ (s2 && b[XLEN-1]);
                            m_hi  <= (f3 != 3'b000);
                            m_tag <= hd.tag;
                        end else if (issue) begin
                            out_valid    <= 1'b1;
                            out_entry    <= hd.tag;
                            out_val      <= alu_res;
                            out_redirect <= alu_redir;
                            if (alu_redir)
                                out_pc <= jalr_tgt;
                        end
                    end
                    S_MUL: begin
                        if (mb[0])
                            acc <= acc + ma;
                        ma  <= ma << 1;
                        mb  <= mb >> 1;
                        cnt <= cnt + CW'(1);
                    end
                    S_DONE: begin
                        out_valid <= 1'b1;
                        out_entry <= m_tag;
                        out_val   <= m_hi ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
